// File: rtl/counter_decoder_pkg.sv
// Shared op and state encodings for the counter decoder.
// Imported by the RTL and the bench.
package counter_decoder_pkg;

  typedef enum logic [1:0] {
    OP_SYNC = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_INIT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'b00,
    ST_TRACK  = 2'b01,
    ST_FAULT  = 2'b10
  } state_e;

endpackage

// File: rtl/counter_decoder_if.sv
// Sample-in / result-out handshake bundle of the counter decoder.
// slave: decoder side, master: producer/consumer side.
interface counter_decoder_if #(
  parameter int BITS = 8
) ();
  logic            i_valid;
  logic            o_ready;
  logic [BITS-1:0] i_value;
  logic            o_valid;
  logic            i_ready;
  logic [1:0]      o_op;
  logic            o_error;

  modport slave (
    input  i_valid, i_value, i_ready,
    output o_ready, o_valid, o_op, o_error
  );

  modport master (
    output i_valid, i_value, i_ready,
    input  o_ready, o_valid, o_op, o_error
  );
endinterface

// File: rtl/counter_decoder_classify.sv
// Combinational step classifier: {prev, value, synced} -> {op, error}.
// Wrap-around arithmetic is mod 2^BITS.
module counter_decoder_classify
  import counter_decoder_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] prev,
  input  logic [BITS-1:0] value,
  input  logic            synced,
  output op_e             op,
  output logic            error
);

  localparam logic [BITS-1:0] ONE = BITS'(1);

  logic [BITS-1:0] up;
  logic [BITS-1:0] dn;

  assign up = prev + ONE;
  assign dn = prev - ONE;

  // INC wins over INIT so 2^BITS-1 -> 0 reads as a wrap
  always_comb begin
    op    = OP_SYNC;
    error = 1'b0;
    if (!synced) begin
      op = (value == '0) ? OP_INIT : OP_SYNC;
    end else if (value == up) begin
      op = OP_INC;
    end else if (value == dn) begin
      op = OP_DEC;
    end else if (value == '0) begin
      op = OP_INIT;
    end else begin
      error = 1'b1;
    end
  end

endmodule

// File: rtl/counter_decoder.sv
// Recovers up/down counter commands from its value stream.
// Stats counters built only with COUNTER_DECODER_STATS_EN.
module counter_decoder
  import counter_decoder_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int CNT_BITS = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_clear,
  counter_decoder_if.slave    bus,
  output logic                o_fault,
  output logic [CNT_BITS-1:0] o_inc_count,
  output logic [CNT_BITS-1:0] o_dec_count,
  output logic [CNT_BITS-1:0] o_err_count
);

  state_e          state_q, state_d;
  logic [BITS-1:0] prev_q, prev_d;
  logic            valid_q, valid_d;
  op_e             op_q, op_d;
  logic            err_q, err_d;
  logic            fault_q, fault_d;
  op_e             cls_op;
  logic            cls_err;
  logic            accept;

  assign bus.o_ready = !valid_q || bus.i_ready;
  assign accept      = bus.i_valid && bus.o_ready;
  assign bus.o_valid = valid_q;
  assign bus.o_op    = op_q;
  assign bus.o_error = err_q;
  assign o_fault     = fault_q;

  counter_decoder_classify #(
    .BITS(BITS)
  ) u_classify (
    .prev  (prev_q),
    .value (bus.i_value),
    .synced(state_q != ST_UNSYNC),
    .op    (cls_op),
    .error (cls_err)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_UNSYNC;
      prev_q  <= '0;
      valid_q <= 1'b0;
      op_q    <= OP_SYNC;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      err_q   <= err_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    valid_d = valid_q && !bus.i_ready;
    op_d    = op_q;
    err_d   = err_q;
    fault_d = fault_q;
    if (i_clear) begin
      state_d = ST_UNSYNC;
      prev_d  = '0;
      valid_d = 1'b0;
      op_d    = OP_SYNC;
      err_d   = 1'b0;
      fault_d = 1'b0;
    end else if (accept) begin
      prev_d  = bus.i_value;
      valid_d = 1'b1;
      op_d    = cls_op;
      err_d   = cls_err;
      if (cls_err) begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
      end else if (state_q == ST_UNSYNC) begin
        state_d = ST_TRACK;
      end
    end
  end

`ifdef COUNTER_DECODER_STATS_EN
  localparam logic [CNT_BITS-1:0] CMAX = '1;
  localparam logic [CNT_BITS-1:0] CONE = CNT_BITS'(1);

  logic [CNT_BITS-1:0] inc_q, dec_q, errc_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inc_q  <= '0;
      dec_q  <= '0;
      errc_q <= '0;
    end else if (i_clear) begin
      inc_q  <= '0;
      dec_q  <= '0;
      errc_q <= '0;
    end else if (accept) begin
      if (cls_op == OP_INC && inc_q != CMAX)
        inc_q <= inc_q + CONE;
      if (cls_op == OP_DEC && dec_q != CMAX)
        dec_q <= dec_q + CONE;
      if (cls_err && errc_q != CMAX)
        errc_q <= errc_q + CONE;
    end
  end

  assign o_inc_count = inc_q;
  assign o_dec_count = dec_q;
  assign o_err_count = errc_q;
`else
  assign o_inc_count = '0;
  assign o_dec_count = '0;
  assign o_err_count = '0;
`endif

endmodule

// File: tb/tb_counter_decoder.sv
// Randomised and directed bench for counter_decoder.
// Reference model works on integer sample history.
module tb_counter_decoder;
  import counter_decoder_pkg::*;

`ifdef COUNTER_DECODER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int CMAXV = 3;

  logic       clock;
  logic       reset;
  logic       i_clear;
  logic       o_fault;
  logic [1:0] o_inc_count;
  logic [1:0] o_dec_count;
  logic [1:0] o_err_count;

  counter_decoder_if #(.BITS(8)) bus ();

  counter_decoder #(
    .BITS    (8),
    .CNT_BITS(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .i_clear    (i_clear),
    .bus        (bus),
    .o_fault    (o_fault),
    .o_inc_count(o_inc_count),
    .o_dec_count(o_dec_count),
    .o_err_count(o_err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  bit   msync;
  int   mprev;
  bit   mv;
  int   mop;
  bit   merr;
  bit   mfault;
  int   minc, mdec, merrc;
  logic seen_ready;
  logic exp_ready;
  bit   last_acc;

  task automatic model_clear();
    msync = 0; mprev = 0; mv = 0; mop = 0;
    merr = 0; mfault = 0;
    minc = 0; mdec = 0; merrc = 0;
  endtask

  function automatic logic [11:0] exp_vec();
    logic [1:0] op;
    op = mv ? 2'(mop) : 2'b00;
    return {exp_ready, mv, op, mv ? merr : 1'b0, mfault,
            2'(minc), 2'(mdec), 2'(merrc)};
  endfunction

  function automatic logic [11:0] obs_vec();
    logic [1:0] op;
    op = bus.o_valid ? bus.o_op : 2'b00;
    return {seen_ready, bus.o_valid, op,
            bus.o_valid ? bus.o_error : 1'b0, o_fault,
            o_inc_count, o_dec_count, o_err_count};
  endfunction

  // Called just after a clock edge; leaves time just after the next edge
  task automatic drive(input logic v, input logic [7:0] val,
                       input logic rdy, input logic clr);
    bit acc;
    int x;
    bus.i_valid = v;
    bus.i_value = val;
    bus.i_ready = rdy;
    i_clear     = clr;
    #3;
    seen_ready = bus.o_ready;
    exp_ready  = !mv || rdy;
    acc = v && exp_ready;
    @(posedge clock);
    if (clr) begin
      model_clear();
    end else begin
      if (mv && rdy) mv = 0;
      if (acc) begin
        x = int'(val);
        merr = 0;
        if (!msync) mop = (x == 0) ? 3 : 0;
        else if (x == (mprev + 1) % 256) mop = 1;
        else if (x == (mprev + 255) % 256) mop = 2;
        else if (x == 0) mop = 3;
        else begin mop = 0; merr = 1; end
        if (STATS && mop == 1 && !merr && minc < CMAXV) minc++;
        if (STATS && mop == 2 && mdec < CMAXV) mdec++;
        if (STATS && merr && merrc < CMAXV) merrc++;
        if (merr) mfault = 1;
        mprev = x; msync = 1; mv = 1;
      end
    end
    last_acc = acc && !clr;
    #1;
  endtask

  task automatic test_reset();
    vectors++;
    if (bus.o_valid !== 1'b0 || bus.o_op !== 2'b00 ||
        bus.o_error !== 1'b0 || o_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got v=%b op=%b e=%b f=%b want 0,00,0,0",
               bus.o_valid, bus.o_op, bus.o_error, o_fault);
    end
    vectors++;
    if ({o_inc_count, o_dec_count, o_err_count} !== 6'd0
        || bus.o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_counts got cnt=%b rdy=%b want 0 rdy=1",
               {o_inc_count, o_dec_count, o_err_count}, bus.o_ready);
    end
  endtask

  task automatic test_basic();
    logic [1:0] want [4] = '{OP_INIT, OP_INC, OP_INC, OP_INC};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(i), 1'b1, 1'b0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL basic_vec[%0d] got %b want %b", i, obs_vec(), exp_vec());
      end
      vectors++;
      if (bus.o_valid !== 1'b1 || bus.o_op !== want[i] ||
          bus.o_error !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_op[%0d] got v=%b op=%b e=%b want 1,%b,0",
                 i, bus.o_valid, bus.o_op, bus.o_error, want[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] seq [6] = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd1, 8'd0};
    logic [1:0] want [6] = '{OP_SYNC, OP_INC, OP_DEC, OP_INC, OP_INC, OP_DEC};
    drive(1'b0, 8'd0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, seq[i], 1'b1, 1'b0);
      vectors++;
      if (bus.o_op !== want[i] || obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL wrap[%0d] got op=%b vec=%b want op=%b vec=%b",
                 i, bus.o_op, obs_vec(), want[i], exp_vec());
      end
    end
  endtask

  task automatic test_error();
    drive(1'b0, 8'd0, 1'b1, 1'b1);
    drive(1'b1, 8'd5, 1'b1, 1'b0);
    drive(1'b1, 8'd9, 1'b1, 1'b0);
    vectors++;
    if (bus.o_op !== OP_SYNC || bus.o_error !== 1'b1 || o_fault !== 1'b1
        || obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL error_step got op=%b e=%b f=%b want 00,1,1",
               bus.o_op, bus.o_error, o_fault);
    end
    drive(1'b1, 8'd10, 1'b1, 1'b0);
    vectors++;
    if (bus.o_op !== OP_INC || bus.o_error !== 1'b0 || o_fault !== 1'b1
        || obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL error_resync got op=%b e=%b f=%b want 01,0,1",
               bus.o_op, bus.o_error, o_fault);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] q[$];
    logic [1:0] held;
    logic rdy;
    held = 2'b00;
    q = '{8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25};
    drive(1'b0, 8'd0, 1'b1, 1'b1);
    drive(1'b1, 8'd19, 1'b1, 1'b0);
    for (int c = 0; c < 30 && q.size() > 0; c++) begin
      rdy = !(c >= 1 && c <= 3);
      drive(1'b1, q[0], rdy, 1'b0);
      if (last_acc) void'(q.pop_front());
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL bp_vec[%0d] got %b want %b", c, obs_vec(), exp_vec());
      end
      if (c == 0) held = bus.o_op;
      if (c >= 1 && c <= 3) begin
        vectors++;
        if (bus.o_op !== held || bus.o_valid !== 1'b1 || seen_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_stall[%0d] got op=%b v=%b rdy=%b want op=%b v=1 rdy=0",
                   c, bus.o_op, bus.o_valid, seen_ready, held);
        end
      end
    end
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL bp_drain got %0d left want 0", q.size());
    end
  endtask

  task automatic test_stats();
    int want;
    want = STATS ? 3 : 0;
    drive(1'b0, 8'd0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b1, 8'(i), 1'b1, 1'b0);
    vectors++;
    if (int'(o_inc_count) != want || obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL stats_sat got inc=%0d want %0d", o_inc_count, want);
    end
    drive(1'b0, 8'd0, 1'b1, 1'b1);
    vectors++;
    if ({o_inc_count, o_dec_count, o_err_count} !== 6'd0
        || bus.o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stats_clear got cnt=%b v=%b want 0,0",
               {o_inc_count, o_dec_count, o_err_count}, bus.o_valid);
    end
    drive(1'b1, 8'd7, 1'b1, 1'b0);
    vectors++;
    if (bus.o_op !== OP_SYNC || bus.o_error !== 1'b0) begin
      miscompares++;
      $display("FAIL stats_unsync got op=%b e=%b want 00,0",
               bus.o_op, bus.o_error);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'd3, 1'b1, 1'b0);
    drive(1'b1, 8'd4, 1'b0, 1'b0);
    vectors++;
    if (bus.o_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_pre got v=%b want 1", bus.o_valid);
    end
    reset = 1'b0;
    #1;
    model_clear();
    vectors++;
    if (bus.o_valid !== 1'b0 || o_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_async got v=%b f=%b want 0,0", bus.o_valid, o_fault);
    end
    reset = 1'b1;
    drive(1'b1, 8'd7, 1'b1, 1'b0);
    vectors++;
    if (bus.o_op !== OP_SYNC || bus.o_error !== 1'b0 || bus.o_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_next got op=%b e=%b v=%b want 00,0,1",
               bus.o_op, bus.o_error, bus.o_valid);
    end
  endtask

  task automatic test_random();
    logic [7:0] lv;
    logic [7:0] val;
    logic v, rdy, clr;
    int r;
    lv = 8'd0;
    for (int i = 0; i < 400; i++) begin
      r   = $urandom_range(0, 9);
      val = (r < 4) ? lv + 8'd1 : (r < 7) ? lv - 8'd1 :
            (r == 7) ? 8'd0 : 8'($urandom_range(0, 255));
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 40) == 0);
      drive(v, val, rdy, clr);
      if (last_acc) lv = val;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random[%0d] got %b want %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset       = 1'b0;
    i_clear     = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_value = '0;
    bus.i_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    reset = 1'b1;
    test_basic();
    test_wrap();
    test_error();
    test_backpressure();
    test_stats();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
